detect_sched: RTL and testbench
===============================

// Module: detect_sched
// PURPOSE
//   Round-robin scheduler that time-shares one serial Moore sequence detector (my_fsm:
//   clock/reset/in/out, detects "100") among N requesters. Each granted requester's
//   W-bit word is cleared into, shifted through and drained from the detector.
//   Returns a per-word hit flag and keeps a saturating hit count.
//   Sits between client blocks and the single detector instance.
// PARAMETERS
//   N        4   number of requesters (>=2)
//   W        8   word width, bits shifted LSB first
//   DET_LAT  2   drain cycles after last bit; detector out still sampled (>=1)
//   CNT_W    8   width of saturating hit counter
// PORTS
//   clock     in   1        system clock, rising edge
//   reset     in   1        synchronous, active-high
//   req       in   N        request per requester; held until gnt
//   data      in   N*W      requester i word at data[i*W +: W]
//   gnt       out  N        one-hot, 1-cycle pulse; data of winner sampled that cycle
//   busy      out  1        high in every state except IDLE
//   done      out  N        one-hot, 1-cycle pulse to the served requester
//   hit       out  1        valid with done: detector out seen high in window
//   hit_cnt   out  CNT_W    total hits since reset, saturates at all-ones
//   det_rst   out  1        drives detector reset
//   det_in    out  1        drives detector serial input
//   det_out   in   1        detector Moore output
// BEHAVIOUR
//   Reset: state=IDLE, rr pointer=0, gnt=0, done=0, hit=0, hit_cnt=0, busy=0, det_in=0.
//     det_rst=1 while reset is high.
//   States: IDLE -> CLEAR -> SHIFT -> DRAIN -> DONE -> IDLE.
//   IDLE: if any req, pick first set req at index >= ptr (wrap mod N).
//     Pulse gnt[k], latch data word k and id k, clear hit accumulator, go to CLEAR.
//     No req: stay in IDLE.
//   CLEAR (1 cycle): det_rst=1, det_in=0.
//   SHIFT (W cycles, bit index b=0..W-1): det_in=word[b].
//     From the 2nd SHIFT cycle onward: acc |= det_out.
//   DRAIN (DET_LAT cycles): det_in=0, acc |= det_out.
//   DONE (1 cycle): done[k]=1, hit=acc.
//     If acc and hit_cnt != all-ones: hit_cnt += 1. ptr=(k+1) mod N.
//   det_rst=0 and det_in=0 outside CLEAR/SHIFT unless in reset.
//   Latency: gnt at cycle T, done at T+2+W+DET_LAT; next gnt no earlier than T+3+W+DET_LAT.
//   Req dropped before gnt: not served. Req held after done: re-arbitrates normally
//     (rr still favours others).
//   Simultaneous reqs: exactly one gnt. A requester waits at most N-1 services.
//   Pattern completing on the last bit is caught in DRAIN and counts as hit.
//   Reset mid-operation: abort immediately to IDLE.
//     No done pulse for the aborted word. ptr=0, hit_cnt=0.
//   hit is meaningful only while done is high; held 0 otherwise.
// TESTING
//   Bench instantiates my_fsm as the detector; W=8, N=4, DET_LAT=2.
//   1) req=0001, data0=8'b0000_0100 (bits 0,0,1,0,0..) -> gnt=0001 at T,
//      done=0001 at T+12, hit=1, hit_cnt=1.
//   2) req=0001, data0=8'hFF, then 8'h00 -> hit=0 both times, hit_cnt unchanged.
//   3) data0=8'b0010_0000 (pattern ends on last bit) -> hit=1 (caught in DRAIN);
//      8'b1000_0000 -> hit=0.
//   4) req=1111 held -> grants in order 0001,0010,0100,1000,0001; gnt spacing 13 cycles;
//      never two gnt bits set at once.
//   5) reset=1 during SHIFT -> next cycle busy=0, det_rst=1, no done;
//      after release, req=0100 granted first time.
//   6) Force 255 hits (CNT_W=8), then one more -> hit_cnt stays 8'hFF, hit still pulses 1.

Source files
------------

// File: rtl/detect_sched.sv
// rtl/detect_sched.sv - round-robin scheduler time-sharing one serial "100" detector among N requesters
module detect_sched #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int DET_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   data,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic [N-1:0]     done,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             det_rst,
  output logic             det_in,
  input  logic             det_out
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2((W > DET_LAT) ? W : DET_LAT) + 1;
  localparam logic [IDW:0]   N_W  = (IDW+1)'(N);
  localparam logic [N-1:0]   ONE  = N'(1);
  localparam logic [CW-1:0]  LAST_BIT   = CW'(W - 1);
  localparam logic [CW-1:0]  LAST_DRAIN = CW'(DET_LAT - 1);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(N - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [W-1:0]   word;
  logic [CW-1:0]  cnt;
  logic           acc;
  logic           det_rst_r;

  logic           found;
  logic [IDW-1:0] pick;
  logic [W-1:0]   pick_word;
  logic [IDW:0]   cand;

  // Scan from the round-robin pointer upward with wrap; first set request wins.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_word = '0;
    cand      = '0;
    for (int j = 0; j < N; j++) begin
      cand = {1'b0, ptr} + (IDW+1)'(j);
      if (cand >= N_W) cand = cand - N_W;
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == pick) pick_word = data[i*W +: W];
    end
  end

  // Detector is held in reset by the scheduler's own reset as well as during CLEAR.
  assign det_rst = det_rst_r | reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      word      <= '0;
      cnt       <= '0;
      acc       <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      hit       <= 1'b0;
      hit_cnt   <= '0;
      busy      <= 1'b0;
      det_in    <= 1'b0;
      det_rst_r <= 1'b0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      hit       <= 1'b0;
      det_in    <= 1'b0;
      det_rst_r <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (found) begin
            gnt       <= ONE << pick;
            word      <= pick_word;
            id        <= pick;
            acc       <= 1'b0;
            state     <= CLEAR;
            busy      <= 1'b1;
            det_rst_r <= 1'b1;
          end
        end
        CLEAR: begin
          state  <= SHIFT;
          cnt    <= '0;
          det_in <= word[0];
          word   <= word >> 1;
        end
        SHIFT: begin
          // The first SHIFT cycle still shows the post-reset output, so skip it.
          if (cnt != '0) acc <= acc | det_out;
          if (cnt == LAST_BIT) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt    <= cnt + CW'(1);
            det_in <= word[0];
            word   <= word >> 1;
          end
        end
        DRAIN: begin
          acc <= acc | det_out;
          if (cnt == LAST_DRAIN) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= ONE << id;
          hit   <= acc;
          if (acc && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
          ptr   <= (id == LAST_ID) ? '0 : id + IDW'(1);
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detect_sched.sv
// tb/tb_detect_sched.sv - directed self-checking bench for detect_sched with a "100" Moore detector
module tb_detect_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [31:0] data  = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  done;
  logic        hit;
  logic [7:0]  hit_cnt;
  logic        det_rst;
  logic        det_in;
  logic        det_out;

  int cyc = 0;
  int nerr = 0;
  int nchk = 0;
  int exp_cnt = 0;
  int multi_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if ($countones(gnt) > 1) multi_cnt <= multi_cnt + 1;

  detect_sched #(.N(4), .W(8), .DET_LAT(2), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .done(done), .hit(hit), .hit_cnt(hit_cnt), .det_rst(det_rst), .det_in(det_in),
    .det_out(det_out)
  );

  my_fsm u_det (.clock(clock), .reset(det_rst), .in(det_in), .out(det_out));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int t);
    int n = 0;
    while (gnt == 4'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    t = cyc;
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    while (done == 4'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    t = cyc;
  endtask

  task automatic serve(input int k, input logic [7:0] w, input logic eh);
    int tg;
    int td;
    logic [3:0] oh;
    oh = 4'b0001 << k;
    data[k*8 +: 8] = w;
    req = oh;
    wait_gnt(tg);
    check("gnt", {28'b0, gnt}, {28'b0, oh});
    req = '0;
    @(negedge clock);
    wait_done(td);
    check("done", {28'b0, done}, {28'b0, oh});
    check("latency", td - tg, 12);
    check("hit", {31'b0, hit}, {31'b0, eh});
    if (eh && exp_cnt != 255) exp_cnt++;
    check("hit_cnt", {24'b0, hit_cnt}, exp_cnt);
  endtask

  initial begin
    int t;
    int prev;
    int nd;

    repeat (3) @(negedge clock);
    check("rst_gnt", {28'b0, gnt}, 0);
    check("rst_done", {28'b0, done}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_hit", {31'b0, hit}, 0);
    check("rst_hit_cnt", {24'b0, hit_cnt}, 0);
    check("rst_det_in", {31'b0, det_in}, 0);
    check("rst_det_rst", {31'b0, det_rst}, 1);
    reset = 1'b0;
    @(negedge clock);
    check("idle_det_rst", {31'b0, det_rst}, 0);

    // 1) pattern in the middle of the word
    serve(0, 8'b0000_0100, 1'b1);
    @(negedge clock);
    check("hit_after_done", {31'b0, hit}, 0);
    check("done_after_done", {28'b0, done}, 0);

    // 2) no pattern
    serve(0, 8'hFF, 1'b0);
    serve(0, 8'h00, 1'b0);

    // 3) pattern completing on last bit, and a trailing 1 that must not count
    serve(0, 8'b0010_0000, 1'b1);
    serve(0, 8'b1000_0000, 1'b0);

    // 4) all requesting: round-robin order and spacing
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_cnt = 0;
    data = '0;
    req = 4'hF;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(t);
      check("rr_gnt", {28'b0, gnt}, 32'(4'b0001 << (i % 4)));
      if (i > 0) check("rr_spacing", t - prev, 13);
      prev = t;
      if (i == 4) req = '0;
      @(negedge clock);
    end
    wait_done(t);
    check("rr_last_done", {28'b0, done}, 1);
    check("rr_hit_cnt", {24'b0, hit_cnt}, 0);

    // 5) reset during SHIFT aborts without a done pulse
    serve(2, 8'b0000_0100, 1'b1);
    data[15:8] = 8'hA5;
    req = 4'b0010;
    wait_gnt(t);
    check("abort_gnt", {28'b0, gnt}, 32'h2);
    req = '0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_det_rst", {31'b0, det_rst}, 1);
    check("abort_done", {28'b0, done}, 0);
    check("abort_hit_cnt", {24'b0, hit_cnt}, 0);
    reset = 1'b0;
    exp_cnt = 0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done != 4'b0) nd++;
    end
    check("abort_no_done", nd, 0);
    serve(2, 8'h00, 1'b0);

    // 6) counter saturation
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 255; i++) serve(0, 8'b0000_0100, 1'b1);
    check("sat_255", {24'b0, hit_cnt}, 255);
    serve(0, 8'b0000_0100, 1'b1);
    check("sat_hold", {24'b0, hit_cnt}, 255);

    check("gnt_onehot", multi_cnt, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

module my_fsm (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);
  typedef enum logic [1:0] {S0, S1, S10, S100} st_t;
  st_t st;
  always_ff @(posedge clock) begin
    if (reset) st <= S0;
    else begin
      case (st)
        S0:      st <= in ? S1 : S0;
        S1:      st <= in ? S1 : S10;
        S10:     st <= in ? S1 : S100;
        default: st <= in ? S1 : S0;
      endcase
    end
  end
  assign out = (st == S100);
endmodule
